mem_ctrl: RTL

Synchronous bus-cycle generator that sits directly upstream of the asynchronous byte-wide memory on the system bus. Accepts single-byte read/write requests from a clocked master over a req/ack handshake. Turns each request into a glitch-free memory cycle on `s_`, `mr_`, `mw_`, the address bus and the bidirectional `d7_d0`, with a programmable number of strobe wait states. Returns read data to the master.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_ctrl_wait_counter.sv | 27 ++
 rtl/mem_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide memory bus-cycle generator:
// FSM state encoding, default parameter values and counter width.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEFAULT      = 16;
  localparam int unsigned WAIT_STATES_DEFAULT = 2;
  localparam int unsigned WAIT_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_wait_counter.sv
// Loadable 4-bit down-counter that times the strobe phase of a memory cycle.
// Holds at zero until reloaded.
module wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] value,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WAIT_CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Bus-cycle generator for an asynchronous byte-wide memory: turns req/ack
// single-byte requests into registered s_/mr_/mw_/addr/data cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [7:0]        d7_d0,
  output logic              s_,
  output logic              mr_,
  output logic              mw_
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_t     state;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       drive_en;
  logic       cnt_load;
  logic       cnt_zero;

  // Counter is loaded on the SETUP->STROBE edge, so it reaches zero on the
  // last STROBE cycle after exactly WAIT_STATES decrements.
  assign cnt_load = (state == SETUP);

  wait_counter u_wait_counter (
    .clock  (clock),
    .reset_ (reset_),
    .load   (cnt_load),
    .value  (WAIT_LOAD),
    .zero   (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state    <= IDLE;
      s_       <= 1'b1;
      mr_      <= 1'b1;
      mw_      <= 1'b1;
      drive_en <= 1'b0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      addr     <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            addr     <= addr_in;
            wdata_q  <= wdata;
            drive_en <= we;
            s_       <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          mr_   <= we_q;
          mw_   <= ~we_q;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt_zero) begin
            mr_   <= 1'b1;
            mw_   <= 1'b1;
            ack   <= 1'b1;
            state <= HOLD;
            if (!we_q) begin
              rdata <= d7_d0;
            end
          end
        end
        HOLD: begin
          s_       <= 1'b1;
          drive_en <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign d7_d0 = drive_en ? wdata_q : 8'bz;

endmodule
